pcileech_cfgmgmt_arbiter: RTL and testbench

Shares the PCIe core's configuration-management port (cfg_mgmt_* signals of the PCIe signal bundle) between up to NREQ independent requesters, e.g. host-side config FIFO, shadow config-space writer, and link/DSN setup logic. It grants round-robin and sequences one read or write at a time through the core's rd_en/wr_en to rd_wr_done handshake. It returns the result to the granted requester and aborts with a timeout response if the core never completes. It sits in the PCIe clock domain between the requesters and the core's mpm-side cfg_mgmt outputs and inputs.

---
 rtl/pcileech_cfgmgmt_arbiter_pkg.sv | 22 ++
 rtl/pcileech_rr_arbiter.sv | 45 ++++
 rtl/pcileech_cfgmgmt_arbiter.sv | 133 +++++++++++++
 tb/tb_pcileech_cfgmgmt_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_cfgmgmt_arbiter_pkg.sv
// Shared types for the cfg_mgmt port arbiter.
// State encoding, request bundle and abort data pattern.
package pcileech_cfgmgmt_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic        we;
      logic [9:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic        ro;
      logic        rw1c;
   } cfg_req_t;

   localparam logic [31:0] CFGMGMT_TIMEOUT_DATA = 32'hFFFFFFFF;

endpackage

// File: rtl/pcileech_rr_arbiter.sv
// Round-robin grant selection for the cfg_mgmt arbiter.
// Only last_grant is stored; the pick itself is combinational.
module pcileech_rr_arbiter
   import pcileech_cfgmgmt_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx,
   output logic            any
);

   logic [IW-1:0] last_grant;
   int            idx;

   // Search starts one past the previous winner and wraps.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_grant) + k) % NREQ;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant_idx  = IW'(idx);
            grant[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= IW'(NREQ - 1);
      end else if (advance) begin
         last_grant <= grant_idx;
      end
   end

endmodule

// File: rtl/pcileech_cfgmgmt_arbiter.sv
// Shares the PCIe core cfg_mgmt port between NREQ requesters,
// one transaction at a time, with a timeout abort.
module pcileech_cfgmgmt_arbiter
   import pcileech_cfgmgmt_arbiter_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic               clk_pcie,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*10-1:0] req_addr,
   input  logic [NREQ*32-1:0] req_data,
   input  logic [NREQ*4-1:0]  req_be,
   input  logic [NREQ-1:0]    req_ro,
   input  logic [NREQ-1:0]    req_rw1c,
   output logic [NREQ-1:0]    req_ready,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [31:0]        rsp_data,
   output logic               rsp_timeout,
   output logic               busy,
   output logic               cfg_mgmt_rd_en,
   output logic               cfg_mgmt_wr_en,
   output logic [9:0]         cfg_mgmt_dwaddr,
   output logic [31:0]        cfg_mgmt_di,
   output logic [3:0]         cfg_mgmt_byte_en,
   output logic               cfg_mgmt_wr_readonly,
   output logic               cfg_mgmt_wr_rw1c_as_rw,
   input  logic [31:0]        cfg_mgmt_do,
   input  logic               cfg_mgmt_rd_wr_done
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [15:0] TO = 16'(TIMEOUT_CYC);

   state_t          state;
   logic [15:0]     cnt;
   logic [IW-1:0]   cur;
   logic [NREQ-1:0] grant;
   logic [IW-1:0]   gidx;
   logic            any;
   logic            advance;
   cfg_req_t        sel;

   assign advance = (state == ST_IDLE) && any;

   pcileech_rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk       (clk_pcie),
      .rst_n     (rst_n),
      .req       (req_valid),
      .advance   (advance),
      .grant     (grant),
      .grant_idx (gidx),
      .any       (any)
   );

   always_comb begin
      sel.we   = req_we[gidx];
      sel.addr = req_addr[int'(gidx)*10 +: 10];
      sel.data = req_data[int'(gidx)*32 +: 32];
      sel.be   = req_be[int'(gidx)*4 +: 4];
      sel.ro   = req_ro[gidx];
      sel.rw1c = req_rw1c[gidx];
   end

   always_ff @(posedge clk_pcie or negedge rst_n) begin
      if (!rst_n) begin
         state                  <= ST_IDLE;
         cnt                    <= '0;
         cur                    <= '0;
         req_ready              <= '0;
         rsp_valid              <= '0;
         rsp_data               <= '0;
         rsp_timeout            <= 1'b0;
         busy                   <= 1'b0;
         cfg_mgmt_rd_en         <= 1'b0;
         cfg_mgmt_wr_en         <= 1'b0;
         cfg_mgmt_dwaddr        <= '0;
         cfg_mgmt_di            <= '0;
         cfg_mgmt_byte_en       <= '0;
         cfg_mgmt_wr_readonly   <= 1'b0;
         cfg_mgmt_wr_rw1c_as_rw <= 1'b0;
      end else begin
         req_ready <= '0;
         rsp_valid <= '0;
         unique case (state)
            ST_IDLE: begin
               if (any) begin
                  cur                    <= gidx;
                  req_ready              <= grant;
                  cfg_mgmt_rd_en         <= !sel.we;
                  cfg_mgmt_wr_en         <= sel.we;
                  cfg_mgmt_dwaddr        <= sel.addr;
                  cfg_mgmt_di            <= sel.data;
                  cfg_mgmt_byte_en       <= sel.be;
                  cfg_mgmt_wr_readonly   <= sel.we & sel.ro;
                  cfg_mgmt_wr_rw1c_as_rw <= sel.we & sel.rw1c;
                  cnt                    <= 16'd1;
                  busy                   <= 1'b1;
                  state                  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // Done is checked first so it beats a same-cycle timeout.
               if (cfg_mgmt_rd_wr_done) begin
                  cfg_mgmt_rd_en <= 1'b0;
                  cfg_mgmt_wr_en <= 1'b0;
                  rsp_data       <= cfg_mgmt_do;
                  rsp_timeout    <= 1'b0;
                  rsp_valid      <= NREQ'(1) << cur;
                  state          <= ST_RESP;
               end else if (cnt == TO) begin
                  cfg_mgmt_rd_en <= 1'b0;
                  cfg_mgmt_wr_en <= 1'b0;
                  rsp_data       <= CFGMGMT_TIMEOUT_DATA;
                  rsp_timeout    <= 1'b1;
                  rsp_valid      <= NREQ'(1) << cur;
                  state          <= ST_RESP;
               end else if (cnt != 16'hFFFF) begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_RESP: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pcileech_cfgmgmt_arbiter.sv
// Self-checking bench: transaction-level model of the cfg_mgmt
// arbiter plus a simple core model with programmable latency.
module tb_pcileech_cfgmgmt_arbiter;

   localparam int N  = 4;
   localparam int TO = 8;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req_valid, req_we, req_ro, req_rw1c;
   logic [N*10-1:0] req_addr;
   logic [N*32-1:0] req_data;
   logic [N*4-1:0]  req_be;
   logic [N-1:0]  req_ready, rsp_valid;
   logic [31:0]   rsp_data;
   logic          rsp_timeout, busy;
   logic          rd_en, wr_en, wr_ro, wr_rw1c;
   logic [9:0]    dwaddr;
   logic [31:0]   di, core_do;
   logic [3:0]    byte_en;
   logic          done;

   pcileech_cfgmgmt_arbiter #(.NREQ(N), .TIMEOUT_CYC(TO)) dut (
      .clk_pcie               (clk),
      .rst_n                  (rst_n),
      .req_valid              (req_valid),
      .req_we                 (req_we),
      .req_addr               (req_addr),
      .req_data               (req_data),
      .req_be                 (req_be),
      .req_ro                 (req_ro),
      .req_rw1c               (req_rw1c),
      .req_ready              (req_ready),
      .rsp_valid              (rsp_valid),
      .rsp_data               (rsp_data),
      .rsp_timeout            (rsp_timeout),
      .busy                   (busy),
      .cfg_mgmt_rd_en         (rd_en),
      .cfg_mgmt_wr_en         (wr_en),
      .cfg_mgmt_dwaddr        (dwaddr),
      .cfg_mgmt_di            (di),
      .cfg_mgmt_byte_en       (byte_en),
      .cfg_mgmt_wr_readonly   (wr_ro),
      .cfg_mgmt_wr_rw1c_as_rw (wr_rw1c),
      .cfg_mgmt_do            (core_do),
      .cfg_mgmt_rd_wr_done    (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Requester side: request i is pending while issued > granted.
   logic        f_we[N];
   logic [9:0]  f_addr[N];
   logic [31:0] f_data[N];
   logic [3:0]  f_be[N];
   logic        f_ro[N];
   logic        f_rw[N];
   int          issued[N];
   int          granted[N];
   int          lat;

   always_comb begin
      req_valid = '0;
      req_we    = '0;
      req_ro    = '0;
      req_rw1c  = '0;
      req_addr  = '0;
      req_data  = '0;
      req_be    = '0;
      for (int i = 0; i < N; i++) begin
         req_valid[i]         = issued[i] > granted[i];
         req_we[i]            = f_we[i];
         req_ro[i]            = f_ro[i];
         req_rw1c[i]          = f_rw[i];
         req_addr[i*10 +: 10] = f_addr[i];
         req_data[i*32 +: 32] = f_data[i];
         req_be[i*4 +: 4]     = f_be[i];
      end
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   function automatic int rr_pick(logic [N-1:0] v, int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   // Model state
   logic [N-1:0] pv;
   int  m_last, m_g, en_cnt, exp_en, core_cnt, rd_cycles;
   logic m_busy, samp, exp_to;
   int  gq[$];
   int  l_en, l_idx;
   logic [31:0] l_data;
   logic l_to;
   logic s_rd, s_wr, s_ro, s_rw;
   logic [9:0] s_addr;
   logic [31:0] s_di;
   logic [3:0] s_be;

   always @(posedge clk) pv <= rst_n ? req_valid : '0;

   always @(negedge clk) begin
      int eg;
      if (!rst_n) begin
         m_busy   = 1'b0;
         m_last   = N - 1;
         samp     = 1'b1;
         core_cnt = 0;
         done     = 1'b0;
      end else begin
         eg = samp ? rr_pick(pv, m_last) : -1;
         chk("req_ready", 32'(req_ready),
             eg >= 0 ? 32'(1) << eg : 32'd0);
         if (eg >= 0) begin
            m_busy = 1'b1;
            m_g    = eg;
            m_last = eg;
            en_cnt = 0;
            exp_to = !(lat >= 1 && lat <= TO);
            exp_en = exp_to ? TO : lat;
            gq.push_back(eg);
            granted[eg]++;
            s_rd = rd_en; s_wr = wr_en; s_addr = dwaddr;
            s_di = di; s_be = byte_en; s_ro = wr_ro; s_rw = wr_rw1c;
         end
         if (rd_en) rd_cycles++;
         if (m_busy && en_cnt == exp_en) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(1) << m_g);
            chk("en_drop", {rd_en, wr_en}, 0);
            chk("rsp_timeout", rsp_timeout, exp_to);
            if (!f_we[m_g])
               chk("rsp_data", rsp_data,
                   exp_to ? 32'hFFFFFFFF : core_do);
            chk("busy_resp", busy, 1);
            l_en = en_cnt; l_idx = m_g;
            l_data = rsp_data; l_to = rsp_timeout;
            m_busy = 1'b0;
            samp   = 1'b0;
         end else if (m_busy) begin
            en_cnt++;
            chk("rd_en", rd_en, !f_we[m_g]);
            chk("wr_en", wr_en, f_we[m_g]);
            chk("dwaddr", dwaddr, f_addr[m_g]);
            chk("byte_en", byte_en, f_be[m_g]);
            chk("wr_ro", wr_ro, f_we[m_g] & f_ro[m_g]);
            chk("wr_rw1c", wr_rw1c, f_we[m_g] & f_rw[m_g]);
            if (f_we[m_g]) chk("di", di, f_data[m_g]);
            chk("rsp_quiet", 32'(rsp_valid), 0);
            chk("busy_issue", busy, 1);
            samp = 1'b0;
         end else begin
            chk("idle_outs", {rsp_valid, rd_en, wr_en, busy}, 0);
            samp = 1'b1;
         end
         // Core: done on the lat-th enable cycle, never if lat == 0.
         core_cnt = (rd_en | wr_en) ? core_cnt + 1 : 0;
         done = (lat != 0) && (core_cnt == lat);
      end
   end

   task automatic issue(int i, logic we, logic [9:0] a,
                        logic [31:0] d, logic [3:0] b,
                        logic ro, logic rw);
      f_we[i] = we; f_addr[i] = a; f_data[i] = d;
      f_be[i] = b; f_ro[i] = ro; f_rw[i] = rw;
      issued[i]++;
   endtask

   function automatic logic pending();
      for (int i = 0; i < N; i++)
         if (issued[i] > granted[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic settle(string name);
      int n = 0;
      @(posedge clk);
      while ((pending() || m_busy || busy) && n < 500) begin
         @(posedge clk);
         n++;
      end
      chk(name, 32'(n < 500), 1);
      @(negedge clk);
      #1;
   endtask

   initial begin
      int n, r;
      int exp_q[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      rst_n = 1'b0;
      lat = 2;
      core_do = 32'h0;
      done = 1'b0;
      for (int i = 0; i < N; i++) begin
         issued[i] = 0; granted[i] = 0;
         f_we[i] = 0; f_addr[i] = '0; f_data[i] = '0;
         f_be[i] = '0; f_ro[i] = 0; f_rw[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_outs", {req_ready, rsp_valid, rsp_timeout, busy,
                       rd_en, wr_en, wr_ro, wr_rw1c}, 0);

      // Fairness: all four pending from reset, two each.
      for (int i = 0; i < N; i++)
         issue(i, 0, 10'(i + 8), 32'h0, 4'hF, 1, 1);
      for (int i = 0; i < N; i++) issued[i]++;
      core_do = 32'h5A5A0001;
      @(negedge clk);
      #1 rst_n = 1'b1;
      settle("fair_done");
      chk("fair_len", gq.size(), 8);
      for (int i = 0; i < 8; i++)
         chk("fair_order", gq[i], exp_q[i]);

      // Single read, 3-cycle core latency.
      lat = 3;
      core_do = 32'h00100406;
      issue(1, 0, 10'h004, 32'h0, 4'hF, 0, 0);
      settle("read_done");
      chk("read_idx", l_idx, 1);
      chk("read_en_cyc", l_en, 3);
      chk("read_data", l_data, 32'h00100406);
      chk("read_to", l_to, 0);
      chk("read_rd", s_rd, 1);

      // Write with both flags set.
      lat = 2;
      r = rd_cycles;
      issue(2, 1, 10'h001, 32'h00000406, 4'b0011, 1, 1);
      settle("write_done");
      chk("wr_idx", l_idx, 2);
      chk("wr_wr", s_wr, 1);
      chk("wr_addr", s_addr, 10'h001);
      chk("wr_di", s_di, 32'h00000406);
      chk("wr_be", s_be, 4'b0011);
      chk("wr_flags", {s_ro, s_rw}, 2'b11);
      chk("wr_no_rd", rd_cycles - r, 0);

      // Timeout, then a normal read still serviced.
      lat = 0;
      issue(3, 0, 10'h010, 32'h0, 4'hF, 1, 0);
      settle("to_done");
      chk("to_en_cyc", l_en, 8);
      chk("to_flag", l_to, 1);
      chk("to_data", l_data, 32'hFFFFFFFF);
      lat = 1;
      core_do = 32'h12345678;
      issue(0, 0, 10'h020, 32'h0, 4'hF, 0, 0);
      settle("post_to_done");
      chk("post_to_data", l_data, 32'h12345678);
      chk("post_to_flag", l_to, 0);

      // Done on the same cycle as the timeout.
      lat = TO;
      core_do = 32'hCAFEF00D;
      issue(1, 0, 10'h030, 32'h0, 4'hF, 0, 0);
      settle("coll_done");
      chk("coll_en_cyc", l_en, 8);
      chk("coll_flag", l_to, 0);
      chk("coll_data", l_data, 32'hCAFEF00D);

      // Reset during the second enable cycle.
      lat = 0;
      n = gq.size();
      issue(1, 0, 10'h040, 32'h0, 4'hF, 0, 0);
      r = 0;
      while (gq.size() == n && r < 50) begin
         @(posedge clk);
         r++;
      end
      chk("rst_grant_seen", 32'(r < 50), 1);
      issue(0, 0, 10'h050, 32'h0, 4'hF, 0, 0);
      issue(2, 0, 10'h060, 32'h0, 4'hF, 0, 0);
      #3;
      chk("pre_rst_en", rd_en, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_outs", {req_ready, rsp_valid, rsp_timeout, busy,
                        rd_en, wr_en, wr_ro, wr_rw1c}, 0);
      chk("arst_data", rsp_data, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      lat = 1;
      settle("after_rst_done");
      chk("after_rst_first", gq[n + 1], 0);
      chk("after_rst_next", gq[n + 2], 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
